// File: rtl/trdb_packet_scoreboard.sv
// Multi-channel packet scoreboard: buffers expected packets per channel, checks
// every DUT packet against the channel head and keeps saturating statistics.
module trdb_packet_scoreboard #(
   parameter int unsigned NUM_CH      = 1,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned PTYPE_LEN   = 4,
   parameter int unsigned P_LEN       = 7,
   parameter int unsigned PAYLOAD_LEN = 32,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            clear_i,
   input  logic [NUM_CH-1:0]               exp_valid_i,
   output logic [NUM_CH-1:0]               exp_ready_o,
   input  logic [NUM_CH*PTYPE_LEN-1:0]     exp_type_i,
   input  logic [NUM_CH*P_LEN-1:0]         exp_length_i,
   input  logic [NUM_CH*PAYLOAD_LEN-1:0]   exp_payload_i,
   input  logic [NUM_CH-1:0]               act_valid_i,
   input  logic [NUM_CH*PTYPE_LEN-1:0]     act_type_i,
   input  logic [NUM_CH*P_LEN-1:0]         act_length_i,
   input  logic [NUM_CH*PAYLOAD_LEN-1:0]   act_payload_i,
   output logic [CNT_W-1:0]                match_cnt_o,
   output logic [CNT_W-1:0]                mismatch_cnt_o,
   output logic [CNT_W-1:0]                unexpected_cnt_o,
   output logic                            err_o,
   output logic [CH_W-1:0]                 first_err_ch_o,
   output logic [1:0]                      first_err_kind_o,
   output logic [CNT_W-1:0]                first_err_seq_o,
   output logic [NUM_CH-1:0]               pending_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam int unsigned INC_W = CNT_W + 1;
   localparam int unsigned ENT_W = PTYPE_LEN + P_LEN + PAYLOAD_LEN;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   typedef logic [ENT_W-1:0] entry_t;

   entry_t            mem_q [NUM_CH][DEPTH];
   logic [PTR_W-1:0]  wrPtr_q [NUM_CH];
   logic [PTR_W-1:0]  wrPtr_d [NUM_CH];
   logic [PTR_W-1:0]  rdPtr_q [NUM_CH];
   logic [PTR_W-1:0]  rdPtr_d [NUM_CH];
   logic [OCC_W-1:0]  occ_q [NUM_CH];
   logic [OCC_W-1:0]  occ_d [NUM_CH];
   entry_t            expEntry [NUM_CH];
   entry_t            actEntry [NUM_CH];

   logic [NUM_CH-1:0] pushEn, popEn, matchEv, mismatchEv, unexpEv;
   logic [INC_W-1:0]  matchInc, mismatchInc, unexpInc;
   logic              anyErr;
   logic [CH_W-1:0]   errCh;
   logic [1:0]        errKind;

   logic [CNT_W-1:0]  matchCnt_q, matchCnt_d, mismatchCnt_q, mismatchCnt_d;
   logic [CNT_W-1:0]  unexpCnt_q, unexpCnt_d, seqCnt_q, seqCnt_d;
   logic [CNT_W-1:0]  firstErrSeq_q, firstErrSeq_d;
   logic [CH_W-1:0]   firstErrCh_q, firstErrCh_d;
   logic [1:0]        firstErrKind_q, firstErrKind_d;
   logic              err_q, err_d;

   function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a,
                                               input logic [INC_W-1:0] b);
      logic [CNT_W+1:0] s;
      s = {2'b00, a} + {1'b0, b};
      return (s[CNT_W+1:CNT_W] != 2'b00) ? '1 : s[CNT_W-1:0];
   endfunction

   // Per-channel events are decided from registered occupancy only, so an
   // entry pushed this cycle can never satisfy a same-cycle actual.
   always_comb begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
         expEntry[c]   = {exp_type_i[c*PTYPE_LEN +: PTYPE_LEN],
                          exp_length_i[c*P_LEN +: P_LEN],
                          exp_payload_i[c*PAYLOAD_LEN +: PAYLOAD_LEN]};
         actEntry[c]   = {act_type_i[c*PTYPE_LEN +: PTYPE_LEN],
                          act_length_i[c*P_LEN +: P_LEN],
                          act_payload_i[c*PAYLOAD_LEN +: PAYLOAD_LEN]};
         pushEn[c]     = exp_valid_i[c] && (occ_q[c] != OCC_FULL);
         popEn[c]      = act_valid_i[c] && (occ_q[c] != '0);
         matchEv[c]    = popEn[c] && (mem_q[c][rdPtr_q[c]] === actEntry[c]);
         mismatchEv[c] = popEn[c] && !matchEv[c];
         unexpEv[c]    = act_valid_i[c] && (occ_q[c] == '0);
      end
   end

   always_comb begin
      matchInc    = '0;
      mismatchInc = '0;
      unexpInc    = '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
         matchInc    = matchInc + INC_W'(matchEv[c]);
         mismatchInc = mismatchInc + INC_W'(mismatchEv[c]);
         unexpInc    = unexpInc + INC_W'(unexpEv[c]);
      end
   end

   // Walk downward so the lowest-numbered erroring channel is the one kept.
   always_comb begin
      anyErr  = 1'b0;
      errCh   = '0;
      errKind = 2'b00;
      for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
         if (mismatchEv[c] || unexpEv[c]) begin
            anyErr  = 1'b1;
            errCh   = CH_W'(c);
            errKind = mismatchEv[c] ? 2'b01 : 2'b10;
         end
      end
   end

   always_comb begin
      wrPtr_d        = wrPtr_q;
      rdPtr_d        = rdPtr_q;
      occ_d          = occ_q;
      matchCnt_d     = matchCnt_q;
      mismatchCnt_d  = mismatchCnt_q;
      unexpCnt_d     = unexpCnt_q;
      seqCnt_d       = seqCnt_q;
      err_d          = err_q;
      firstErrCh_d   = firstErrCh_q;
      firstErrKind_d = firstErrKind_q;
      firstErrSeq_d  = firstErrSeq_q;
      if (clear_i) begin
         for (int c = 0; c < int'(NUM_CH); c++) begin
            wrPtr_d[c] = '0;
            rdPtr_d[c] = '0;
            occ_d[c]   = '0;
         end
         matchCnt_d     = '0;
         mismatchCnt_d  = '0;
         unexpCnt_d     = '0;
         seqCnt_d       = '0;
         err_d          = 1'b0;
         firstErrCh_d   = '0;
         firstErrKind_d = 2'b00;
         firstErrSeq_d  = '0;
      end else begin
         for (int c = 0; c < int'(NUM_CH); c++) begin
            wrPtr_d[c] = wrPtr_q[c] + PTR_W'(pushEn[c]);
            rdPtr_d[c] = rdPtr_q[c] + PTR_W'(popEn[c]);
            occ_d[c]   = occ_q[c] + OCC_W'(pushEn[c]) - OCC_W'(popEn[c]);
         end
         matchCnt_d    = satAdd(matchCnt_q, matchInc);
         mismatchCnt_d = satAdd(mismatchCnt_q, mismatchInc);
         unexpCnt_d    = satAdd(unexpCnt_q, unexpInc);
         seqCnt_d      = satAdd(seqCnt_q, matchInc + mismatchInc);
         if (anyErr) begin
            err_d = 1'b1;
         end
         if (anyErr && (firstErrKind_q == 2'b00)) begin
            firstErrCh_d   = errCh;
            firstErrKind_d = errKind;
            firstErrSeq_d  = seqCnt_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int c = 0; c < int'(NUM_CH); c++) begin
            wrPtr_q[c] <= '0;
            rdPtr_q[c] <= '0;
            occ_q[c]   <= '0;
         end
         matchCnt_q     <= '0;
         mismatchCnt_q  <= '0;
         unexpCnt_q     <= '0;
         seqCnt_q       <= '0;
         err_q          <= 1'b0;
         firstErrCh_q   <= '0;
         firstErrKind_q <= 2'b00;
         firstErrSeq_q  <= '0;
      end else begin
         wrPtr_q        <= wrPtr_d;
         rdPtr_q        <= rdPtr_d;
         occ_q          <= occ_d;
         matchCnt_q     <= matchCnt_d;
         mismatchCnt_q  <= mismatchCnt_d;
         unexpCnt_q     <= unexpCnt_d;
         seqCnt_q       <= seqCnt_d;
         err_q          <= err_d;
         firstErrCh_q   <= firstErrCh_d;
         firstErrKind_q <= firstErrKind_d;
         firstErrSeq_q  <= firstErrSeq_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
         if (pushEn[c] && !clear_i) begin
            mem_q[c][wrPtr_q[c]] <= expEntry[c];
         end
      end
   end

   always_comb begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
         exp_ready_o[c] = (occ_q[c] != OCC_FULL);
         pending_o[c]   = (occ_q[c] != '0);
      end
   end

   assign match_cnt_o      = matchCnt_q;
   assign mismatch_cnt_o   = mismatchCnt_q;
   assign unexpected_cnt_o = unexpCnt_q;
   assign err_o            = err_q;
   assign first_err_ch_o   = firstErrCh_q;
   assign first_err_kind_o = firstErrKind_q;
   assign first_err_seq_o  = firstErrSeq_q;

endmodule

// File: tb/tb_trdb_packet_scoreboard.sv
// Bench for trdb_packet_scoreboard: four channels, 4-deep FIFOs, 4-bit counters,
// with a queue-based model of the expected packets and statistics.
module tb_trdb_packet_scoreboard;

   localparam int NCH = 4;
   localparam int DEP = 4;
   localparam int CW  = 4;
   localparam int TL  = 4;
   localparam int LL  = 7;
   localparam int PL  = 32;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct packed {
      logic [TL-1:0] t;
      logic [LL-1:0] l;
      logic [PL-1:0] p;
   } pkt_t;

   logic              clk = 1'b0;
   logic              rstN = 1'b0;
   logic              clear = 1'b0;
   logic [NCH-1:0]    expValid = '0, actValid = '0;
   logic [NCH-1:0]    expReady, pending;
   logic [NCH*TL-1:0] expType = '0, actType = '0;
   logic [NCH*LL-1:0] expLen = '0, actLen = '0;
   logic [NCH*PL-1:0] expPay = '0, actPay = '0;
   logic [CW-1:0]     matchCnt, misCnt, unexpCnt, errSeq;
   logic              err;
   logic [1:0]        errCh, errKind;

   pkt_t mq [NCH][$];
   int   mMatch, mMis, mUnexp, mSeq, mCh, mKind, mSeqCap;
   bit   mErr;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   trdb_packet_scoreboard #(
      .NUM_CH(NCH), .DEPTH(DEP), .CNT_W(CW),
      .PTYPE_LEN(TL), .P_LEN(LL), .PAYLOAD_LEN(PL)
   ) dut (
      .clk_i(clk), .rst_ni(rstN), .clear_i(clear),
      .exp_valid_i(expValid), .exp_ready_o(expReady),
      .exp_type_i(expType), .exp_length_i(expLen), .exp_payload_i(expPay),
      .act_valid_i(actValid),
      .act_type_i(actType), .act_length_i(actLen), .act_payload_i(actPay),
      .match_cnt_o(matchCnt), .mismatch_cnt_o(misCnt), .unexpected_cnt_o(unexpCnt),
      .err_o(err), .first_err_ch_o(errCh), .first_err_kind_o(errKind),
      .first_err_seq_o(errSeq), .pending_o(pending)
   );

   function automatic pkt_t mk(input int t, input int l, input int p);
      pkt_t r;
      r.t = TL'(t);
      r.l = LL'(l);
      r.p = PL'(p);
      return r;
   endfunction

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   function automatic logic [NCH-1:0] modelPending();
      logic [NCH-1:0] r;
      for (int c = 0; c < NCH; c++) r[c] = (mq[c].size() != 0);
      return r;
   endfunction

   task automatic modelReset();
      for (int c = 0; c < NCH; c++) mq[c].delete();
      mMatch = 0; mMis = 0; mUnexp = 0; mSeq = 0;
      mCh = 0; mKind = 0; mSeqCap = 0; mErr = 0;
   endtask

   task automatic driveExp(input int c, input pkt_t p);
      expValid[c] = 1'b1;
      expType[c*TL +: TL] = p.t;
      expLen[c*LL +: LL] = p.l;
      expPay[c*PL +: PL] = p.p;
   endtask

   task automatic driveAct(input int c, input pkt_t p);
      actValid[c] = 1'b1;
      actType[c*TL +: TL] = p.t;
      actLen[c*LL +: LL] = p.l;
      actPay[c*PL +: PL] = p.p;
   endtask

   // Update the model with this cycle's stimulus, clock once, release inputs.
   task automatic tick();
      int   nM, nX, nU;
      int   sizeBefore [NCH];
      pkt_t h, a;
      if (clear) begin
         modelReset();
      end else begin
         nM = 0; nX = 0; nU = 0;
         for (int c = 0; c < NCH; c++) sizeBefore[c] = mq[c].size();
         for (int c = 0; c < NCH; c++) begin
            if (actValid[c]) begin
               a = {actType[c*TL +: TL], actLen[c*LL +: LL], actPay[c*PL +: PL]};
               if (sizeBefore[c] > 0) begin
                  h = mq[c].pop_front();
                  if (h === a) nM++;
                  else begin
                     nX++;
                     if (mKind == 0) begin mCh = c; mKind = 1; mSeqCap = mSeq; end
                  end
               end else begin
                  nU++;
                  if (mKind == 0) begin mCh = c; mKind = 2; mSeqCap = mSeq; end
               end
            end
         end
         for (int c = 0; c < NCH; c++)
            if (expValid[c] && sizeBefore[c] < DEP)
               mq[c].push_back({expType[c*TL +: TL], expLen[c*LL +: LL], expPay[c*PL +: PL]});
         mMatch = sat(mMatch + nM);
         mMis   = sat(mMis + nX);
         mUnexp = sat(mUnexp + nU);
         mSeq   = sat(mSeq + nM + nX);
         if (nX + nU > 0) mErr = 1;
      end
      @(posedge clk);
      #1;
      clear = 1'b0;
      expValid = '0;
      actValid = '0;
   endtask

   task automatic doClear();
      clear = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      checks++; if (matchCnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_match: got %0d expected 0", matchCnt); end
      checks++; if (misCnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_mismatch: got %0d expected 0", misCnt); end
      checks++; if (unexpCnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_unexpected: got %0d expected 0", unexpCnt); end
      checks++; if ({err, errCh, errKind, errSeq} !== 9'd0) begin errors++; $display("[TB] FAIL reset_err: got err=%b ch=%0d kind=%b seq=%0d expected all 0", err, errCh, errKind, errSeq); end
      checks++; if (pending !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pending: got %b expected 0000", pending); end
      checks++; if (expReady !== 4'b1111) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1111", expReady); end
   endtask

   task automatic test_match_stream();
      for (int i = 0; i < 3; i++) begin driveExp(0, mk(i + 1, 3 + i, 32'h1000 + i)); tick(); end
      checks++; if (pending !== 4'b0001) begin errors++; $display("[TB] FAIL stream_pending: got %b expected 0001", pending); end
      for (int i = 0; i < 3; i++) begin driveAct(0, mk(i + 1, 3 + i, 32'h1000 + i)); tick(); end
      checks++; if (matchCnt !== 4'd3) begin errors++; $display("[TB] FAIL stream_match: got %0d expected 3", matchCnt); end
      checks++; if (misCnt !== 4'd0 || unexpCnt !== 4'd0) begin errors++; $display("[TB] FAIL stream_errcnt: got mis=%0d unexp=%0d expected 0 0", misCnt, unexpCnt); end
      checks++; if (err !== 1'b0 || pending !== 4'b0000) begin errors++; $display("[TB] FAIL stream_flags: got err=%b pending=%b expected 0 0000", err, pending); end
   endtask

   task automatic test_mismatch();
      doClear();
      driveExp(0, mk(1, 5, 32'hAA)); tick();
      driveAct(0, mk(1, 5, 32'hAB)); tick();
      checks++; if (misCnt !== 4'd1 || err !== 1'b1) begin errors++; $display("[TB] FAIL mis_count: got mis=%0d err=%b expected 1 1", misCnt, err); end
      checks++; if (errKind !== 2'b01 || errSeq !== 4'd0 || errCh !== 2'd0) begin errors++; $display("[TB] FAIL mis_capture: got kind=%b seq=%0d ch=%0d expected 01 0 0", errKind, errSeq, errCh); end
      driveExp(0, mk(2, 3, 32'h55)); tick();
      driveAct(0, mk(2, 3, 32'h55)); tick();
      checks++; if (matchCnt !== 4'd1) begin errors++; $display("[TB] FAIL mis_later_match: got %0d expected 1", matchCnt); end
      checks++; if (errKind !== 2'b01 || errSeq !== 4'd0 || err !== 1'b1) begin errors++; $display("[TB] FAIL mis_capture_hold: got kind=%b seq=%0d err=%b expected 01 0 1", errKind, errSeq, err); end
   endtask

   task automatic test_unexpected();
      doClear();
      driveAct(0, mk(3, 2, 32'h10));
      driveExp(0, mk(3, 2, 32'h10));
      tick();
      checks++; if (unexpCnt !== 4'd1 || matchCnt !== 4'd0) begin errors++; $display("[TB] FAIL unexp_count: got unexp=%0d match=%0d expected 1 0", unexpCnt, matchCnt); end
      checks++; if (pending !== 4'b0001) begin errors++; $display("[TB] FAIL unexp_pending: got %b expected 0001", pending); end
      checks++; if (errKind !== 2'b10 || err !== 1'b1) begin errors++; $display("[TB] FAIL unexp_capture: got kind=%b err=%b expected 10 1", errKind, err); end
      driveAct(0, mk(3, 2, 32'h10)); tick();
      checks++; if (matchCnt !== 4'd1 || pending !== 4'b0000) begin errors++; $display("[TB] FAIL unexp_then_match: got match=%0d pending=%b expected 1 0000", matchCnt, pending); end
   endtask

   task automatic test_full_and_wrap();
      doClear();
      for (int i = 0; i < DEP; i++) begin driveExp(2, mk(2, i, 32'h100 + i)); tick(); end
      checks++; if (expReady !== 4'b1011 || pending !== 4'b0100) begin errors++; $display("[TB] FAIL full_ready: got ready=%b pending=%b expected 1011 0100", expReady, pending); end
      driveExp(2, mk(2, 9, 32'hDEAD)); tick();
      checks++; if (expReady[2] !== 1'b0) begin errors++; $display("[TB] FAIL full_hold: got ready=%b expected 0", expReady[2]); end
      driveAct(2, mq[2][0]); tick();
      checks++; if (expReady[2] !== 1'b1) begin errors++; $display("[TB] FAIL full_release: got ready=%b expected 1", expReady[2]); end
      for (int i = 0; i < 10; i++) begin
         driveExp(2, mk(2, 20 + i, 32'h200 + i));
         driveAct(2, mq[2][0]);
         tick();
         checks++; if (expReady[2] !== 1'b1 || pending[2] !== 1'b1) begin errors++; $display("[TB] FAIL wrap_steady_%0d: got ready=%b pending=%b expected 1 1", i, expReady[2], pending[2]); end
      end
      for (int i = 0; i < 3; i++) begin driveAct(2, mq[2][0]); tick(); end
      checks++; if (matchCnt !== 4'd14 || misCnt !== 4'd0 || unexpCnt !== 4'd0) begin errors++; $display("[TB] FAIL wrap_counts: got match=%0d mis=%0d unexp=%0d expected 14 0 0", matchCnt, misCnt, unexpCnt); end
      checks++; if (pending !== 4'b0000 || expReady !== 4'b1111) begin errors++; $display("[TB] FAIL wrap_drained: got pending=%b ready=%b expected 0000 1111", pending, expReady); end
   endtask

   task automatic test_multi_channel();
      doClear();
      for (int c = 0; c < NCH; c++) driveExp(c, mk(1, 1, 32'hA0 + c));
      tick();
      driveExp(0, mk(6, 6, 32'hC0));
      driveAct(0, mk(1, 1, 32'hA0));
      tick();
      driveAct(0, mk(6, 6, 32'hC0));
      driveAct(1, mk(1, 1, 32'hB1));
      driveAct(2, mk(1, 1, 32'hA2));
      driveAct(3, mk(7, 1, 32'hA3));
      tick();
      checks++; if (misCnt !== 4'd2 || matchCnt !== 4'd3) begin errors++; $display("[TB] FAIL multi_counts: got mis=%0d match=%0d expected 2 3", misCnt, matchCnt); end
      checks++; if (errCh !== 2'd1 || errKind !== 2'b01 || errSeq !== 4'd1) begin errors++; $display("[TB] FAIL multi_capture: got ch=%0d kind=%b seq=%0d expected 1 01 1", errCh, errKind, errSeq); end
      checks++; if (errCh !== 2'(mCh) || errKind !== 2'(mKind) || errSeq !== 4'(mSeqCap)) begin errors++; $display("[TB] FAIL multi_model: got ch=%0d kind=%0d seq=%0d expected %0d %0d %0d", errCh, errKind, errSeq, mCh, mKind, mSeqCap); end
   endtask

   task automatic test_saturation();
      doClear();
      for (int i = 0; i <= 20; i++) begin
         driveExp(0, mk(5, 1, i));
         if (mq[0].size() > 0) driveAct(0, mq[0][0]);
         tick();
      end
      checks++; if (matchCnt !== 4'd15 || 4'(mMatch) !== 4'd15) begin errors++; $display("[TB] FAIL sat_match: got %0d expected 15", matchCnt); end
      driveAct(1, mk(0, 0, 0)); tick();
      checks++; if (errKind !== 2'b10 || errSeq !== 4'd15 || errCh !== 2'd1) begin errors++; $display("[TB] FAIL sat_seq: got kind=%b seq=%0d ch=%0d expected 10 15 1", errKind, errSeq, errCh); end
   endtask

   task automatic test_clear_priority();
      doClear();
      driveExp(1, mk(4, 4, 32'h44)); driveAct(3, mk(0, 0, 0)); tick();
      checks++; if (err !== 1'b1 || pending !== 4'b0010) begin errors++; $display("[TB] FAIL clr_setup: got err=%b pending=%b expected 1 0010", err, pending); end
      clear = 1'b1;
      driveExp(0, mk(8, 8, 32'h88));
      driveAct(1, mk(4, 4, 32'h45));
      tick();
      checks++; if ({matchCnt, misCnt, unexpCnt} !== 12'd0 || err !== 1'b0) begin errors++; $display("[TB] FAIL clr_counts: got match=%0d mis=%0d unexp=%0d err=%b expected 0 0 0 0", matchCnt, misCnt, unexpCnt, err); end
      checks++; if (pending !== 4'b0000 || expReady !== 4'b1111 || {errCh, errKind, errSeq} !== 8'd0) begin errors++; $display("[TB] FAIL clr_state: got pending=%b ready=%b kind=%b expected 0000 1111 00", pending, expReady, errKind); end
      driveAct(0, mk(8, 8, 32'h88)); tick();
      checks++; if (unexpCnt !== 4'd1 || matchCnt !== 4'd0) begin errors++; $display("[TB] FAIL clr_discard: got unexp=%0d match=%0d expected 1 0", unexpCnt, matchCnt); end
   endtask

   task automatic test_async_reset();
      doClear();
      driveExp(0, mk(1, 1, 1)); driveExp(3, mk(2, 2, 2)); tick();
      driveAct(0, mk(1, 1, 1)); driveAct(2, mk(0, 0, 0)); tick();
      checks++; if (matchCnt !== 4'd1 || pending !== 4'b1000 || err !== 1'b1) begin errors++; $display("[TB] FAIL arst_setup: got match=%0d pending=%b err=%b expected 1 1000 1", matchCnt, pending, err); end
      #2 rstN = 1'b0;
      #1;
      checks++; if ({matchCnt, misCnt, unexpCnt} !== 12'd0 || err !== 1'b0 || pending !== 4'b0000 || expReady !== 4'b1111) begin errors++; $display("[TB] FAIL arst_immediate: got match=%0d unexp=%0d err=%b pending=%b ready=%b expected 0 0 0 0000 1111", matchCnt, unexpCnt, err, pending, expReady); end
      modelReset();
      @(negedge clk) rstN = 1'b1;
      driveAct(3, mk(2, 2, 2)); tick();
      checks++; if (unexpCnt !== 4'(mUnexp) || matchCnt !== 4'(mMatch)) begin errors++; $display("[TB] FAIL arst_flushed: got unexp=%0d match=%0d expected %0d %0d", unexpCnt, matchCnt, mUnexp, mMatch); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      test_reset();
      rstN = 1'b1;
      #1;
      test_reset();
      test_match_stream();
      test_mismatch();
      test_unexpected();
      test_full_and_wrap();
      test_multi_channel();
      test_saturation();
      test_clear_priority();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/trdb_packet_scoreboard.md
# trdb_packet_scoreboard

Parametrised, multi-channel packet scoreboard for trace-debugger verification. It sits beside one or more trace_debugger instances in the bench. Per channel, it buffers expected packets (type, length, payload) in a FIFO. It compares each packet the DUT emits against the FIFO head and keeps saturating match/mismatch/unexpected counters, a sticky error flag and a first-error capture. It replaces per-cycle vector-indexed checking with handshake-driven, latency-tolerant checking.

## Interface
- NUM_CH, 1: number of independent packet channels (1..8).
- DEPTH, 8: expected-packet FIFO entries per channel; power of two, ≥2.
- CNT_W, 16: width of each statistics counter.
- PTYPE_LEN / P_LEN / PAYLOAD_LEN: field widths, taken from trdb_pkg.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous flush of FIFOs, counters, flags.
- exp_valid_i  in  NUM_CH  expected packet valid, one bit per channel.
- exp_ready_o  out  NUM_CH  channel FIFO not full.
- exp_type_i  in  NUM_CH*PTYPE_LEN  expected packet types; channel c uses slice [c*PTYPE_LEN +: PTYPE_LEN].
- exp_length_i  in  NUM_CH*P_LEN  expected lengths, same slicing.
- exp_payload_i  in  NUM_CH*PAYLOAD_LEN  expected payloads, same slicing.
- act_valid_i  in  NUM_CH  DUT packet valid; no back-pressure.
- act_type_i / act_length_i / act_payload_i  in  as exp_*  DUT packet fields.
- match_cnt_o  out  CNT_W  packets equal to head.
- mismatch_cnt_o  out  CNT_W  packets differing from head.
- unexpected_cnt_o  out  CNT_W  packets arriving with empty FIFO.
- err_o  out  1  sticky; set by any mismatch or unexpected event.
- first_err_ch_o  out  $clog2(NUM_CH) (min 1)  channel of first error.
- first_err_kind_o  out  2  00 none, 01 mismatch, 10 unexpected.
- first_err_seq_o  out  CNT_W  total compares (all channels) before first error.
- pending_o  out  NUM_CH  channel FIFO non-empty.

## Operation
- Push: exp_valid_i[c] & exp_ready_o[c] writes the entry at the channel's tail. exp_ready_o[c] = !full[c], combinational from registered occupancy.
- Compare: act_valid_i[c] with FIFO c non-empty (registered state):
  - all three fields equal head (=== semantics) → match. Otherwise → mismatch.
  - Head is popped in both cases.
- act_valid_i[c] with FIFO c empty → unexpected. No pop. An entry pushed in the same cycle is stored and is not bypassed.
- Push and pop on the same channel in one cycle: occupancy unchanged, pointers both advance. Legal when not full.
- Counters: each adds the number of channels with that event this cycle (0..NUM_CH) and saturates at all-ones. A saturated counter holds.
- Sequence count: internal CNT_W counter of match+mismatch events, saturating.
- First-error capture: written only while first_err_kind_o == 00.
  - Lowest-numbered erroring channel wins on simultaneous errors.
  - first_err_seq_o captures the sequence count before this cycle's increments.
- clear_i has priority over every same-cycle event: FIFOs empty, counters and capture zeroed, err_o low. Pushes and actuals in that cycle are discarded.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Full/empty are tracked by occupancy count of log2(DEPTH)+1 bits.

## Timing
- Reset (async assert, sync release): every counter 0, err_o 0, first_err_* 0, pending_o 0, exp_ready_o all 1, FIFOs empty.
- Latency: an event in cycle N is visible on the counters, err_o and first_err_* after edge N+1. pending_o and exp_ready_o also update at edge N+1.
- A push is comparable from the cycle after acceptance.
- Reset asserted mid-operation discards all buffered entries immediately, without waiting for a clock.
- Throughput: one push and one compare per channel per cycle, sustained.

## Test plan
- NUM_CH=1: push 3 packets, replay identical actuals one per cycle → match_cnt_o=3, mismatch/unexpected 0, err_o=0, pending_o=0.
- Push type=4'h1 len=5 payload=0xAA; actual payload=0xAB → mismatch_cnt_o=1, err_o=1, first_err_kind_o=01, first_err_seq_o=0. A later match increments match_cnt_o, and the capture stays unchanged.
- Actual with empty FIFO, plus a push on the same cycle → unexpected_cnt_o=1. Next cycle pending_o=1. A following identical actual → match_cnt_o=1.
- DEPTH=4: push 4 entries → exp_ready_o=0. A 5th push is held. Push and compare on the same cycle once non-full → occupancy stays constant. Wrap pointers past 2*DEPTH pushes with no corruption.
- NUM_CH=4: channels 1 and 3 mismatch in the same cycle → mismatch_cnt_o increments by 2, first_err_ch_o=1. CNT_W=4: 20 matches → match_cnt_o=15.
- Assert clear_i together with a push and an actual → all outputs return to reset values. Assert rst_ni low mid-stream → outputs reset asynchronously.
